// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared definitions for the VGA raster timing generator:
//   - default segment lengths for 640x480@60 (25.175 MHz pixel clock)
//   - sync polarity enum
//   - helpers that turn segment lengths into axis totals and decode a
//     position on an axis into its sync / active membership
// -----------------------------------------------------------------------------
package vga_timing_pkg;

   typedef enum logic {
      SYNC_NEG = 1'b0,
      SYNC_POS = 1'b1
   } sync_pol_e;

   localparam int DEF_H_SYNC   = 32'sd96;
   localparam int DEF_H_BACK   = 32'sd48;
   localparam int DEF_H_ACTIVE = 32'sd640;
   localparam int DEF_H_FRONT  = 32'sd16;
   localparam int DEF_V_SYNC   = 32'sd2;
   localparam int DEF_V_BACK   = 32'sd33;
   localparam int DEF_V_ACTIVE = 32'sd480;
   localparam int DEF_V_FRONT  = 32'sd10;

   // Length of a whole axis (sync + back porch + active + front porch).
   function automatic int axis_total(input int sync_len, input int back_len,
                                     input int active_len, input int front_len);
      return sync_len + back_len + active_len + front_len;
   endfunction

   // Sync is always the first segment of an axis.
   function automatic logic seg_in_sync(input int pos, input int sync_len);
      return (pos < sync_len);
   endfunction

   function automatic logic seg_in_active(input int pos, input int start, input int len);
      return (pos >= start) && (pos < (start + len));
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One raster axis: a position counter 0..TOTAL-1 that advances on step and
// wraps, plus a decode of the position it will hold after this edge.
// The decode outputs are combinational on purpose: the top registers them, so
// its registered outputs always match the counter value they were taken from.
//
// Ports:
//   pixel_clock  in   pixel clock, rising edge
//   reset        in   asynchronous active-low reset
//   step         in   advance the counter on this edge
//   wrap         out  counter currently at TOTAL-1 (next step returns to 0)
//   in_sync      out  next position lies in the sync segment
//   in_active    out  next position lies in the active segment
//   coord        out  next position's active coordinate, all-ones outside
// With VGA_TIMING_PREFETCH_EN defined, also:
//   ahead_step   in   the axis advances on the step after this one
//   next_wrap    out  next position is TOTAL-1
//   ahead_active out  active flag of the position one step past next
//   ahead_coord  out  coordinate of the position one step past next
// -----------------------------------------------------------------------------
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int SYNC_LEN   = DEF_H_SYNC,
   parameter int BACK_LEN   = DEF_H_BACK,
   parameter int ACTIVE_LEN = DEF_H_ACTIVE,
   parameter int FRONT_LEN  = DEF_H_FRONT,
   parameter int COORD_W    = 32'sd10
) (
   input  logic               pixel_clock,
   input  logic               reset,
   input  logic               step,
`ifdef VGA_TIMING_PREFETCH_EN
   input  logic               ahead_step,
   output logic               next_wrap,
   output logic               ahead_active,
   output logic [COORD_W-1:0] ahead_coord,
`endif
   output logic               wrap,
   output logic               in_sync,
   output logic               in_active,
   output logic [COORD_W-1:0] coord
);

   localparam int TOTAL     = axis_total(SYNC_LEN, BACK_LEN, ACTIVE_LEN, FRONT_LEN);
   localparam int CNT_W     = (TOTAL > 32'sd1) ? $clog2(TOTAL) : 32'sd1;
   localparam int LAST      = TOTAL - 32'sd1;
   localparam int ACT_START = SYNC_LEN + BACK_LEN;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Coordinate is computed in 32-bit arithmetic so nothing is lost before
   // narrowing; the active length is known to fit COORD_W.
   function automatic logic [COORD_W-1:0] pos_coord(input int pos);
      int rel;
      rel = pos - ACT_START;
      if (seg_in_active(pos, ACT_START, ACTIVE_LEN)) begin
         return rel[COORD_W-1:0];
      end else begin
         return '1;
      end
   endfunction

   assign wrap = (int'(cnt_q) == LAST);

   // Next counter value: hold, increment, or wrap to zero.
   always_comb begin
      cnt_d = cnt_q;
      if (step) begin
         if (wrap) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Position register.
   always_ff @(posedge pixel_clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Decode of the next position, registered by the top.
   always_comb begin
      in_sync   = seg_in_sync(int'(cnt_d), SYNC_LEN);
      in_active = seg_in_active(int'(cnt_d), ACT_START, ACTIVE_LEN);
      coord     = pos_coord(int'(cnt_d));
   end

`ifdef VGA_TIMING_PREFETCH_EN
   int ahead_pos_s;

   assign next_wrap = (int'(cnt_d) == LAST);

   // Position one step beyond the next one, wrap included.
   always_comb begin
      ahead_pos_s = int'(cnt_d);
      if (!ahead_step) begin
         ahead_pos_s = int'(cnt_d);
      end else if (next_wrap) begin
         ahead_pos_s = 32'sd0;
      end else begin
         ahead_pos_s = int'(cnt_d) + 32'sd1;
      end
      ahead_active = seg_in_active(ahead_pos_s, ACT_START, ACTIVE_LEN);
      ahead_coord  = pos_coord(ahead_pos_s);
   end
`endif

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// VGA raster timing generator. Horizontal and vertical position counters
// (one vga_axis_counter each) are decoded into sync, active-video, pixel
// coordinates and line/frame markers. All outputs are registered from the
// decode of the next counter state, so they are glitch-free and line up with
// the counters with no extra latency. With ce low everything holds.
//
// Ports:
//   pixel_clock  in   pixel clock, rising edge
//   reset        in   asynchronous active-low reset
//   ce           in   pixel-step enable
//   hsync        out  horizontal sync, asserted level HSYNC_POL
//   vsync        out  vertical sync, asserted level VSYNC_POL
//   active       out  both axes in their active segment
//   x            out  active column, all-ones outside horizontal active
//   y            out  active row, all-ones outside vertical active
//   line_start   out  first pixel of an active line
//   frame_start  out  first pixel of the frame
// Optional feature, enabled by defining VGA_TIMING_PREFETCH_EN:
//   fetch_x, fetch_y, fetch_valid  x / y / active for the position one
//   enabled step ahead, for frame buffers with one cycle of read latency.
// -----------------------------------------------------------------------------
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BACK    = DEF_H_BACK,
   parameter int H_ACTIVE  = DEF_H_ACTIVE,
   parameter int H_FRONT   = DEF_H_FRONT,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BACK    = DEF_V_BACK,
   parameter int V_ACTIVE  = DEF_V_ACTIVE,
   parameter int V_FRONT   = DEF_V_FRONT,
   parameter bit HSYNC_POL = SYNC_NEG,
   parameter bit VSYNC_POL = SYNC_NEG,
   parameter int X_WIDTH   = 32'sd10,
   parameter int Y_WIDTH   = 32'sd10
) (
   input  logic               pixel_clock,
   input  logic               reset,
   input  logic               ce,
   output logic               hsync,
   output logic               vsync,
   output logic               active,
   output logic [X_WIDTH-1:0] x,
   output logic [Y_WIDTH-1:0] y,
`ifdef VGA_TIMING_PREFETCH_EN
   output logic [X_WIDTH-1:0] fetch_x,
   output logic [Y_WIDTH-1:0] fetch_y,
   output logic               fetch_valid,
`endif
   output logic               line_start,
   output logic               frame_start
);

   localparam int H_TOTAL     = axis_total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
   localparam int V_TOTAL     = axis_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);
   localparam int H_ACT_START = H_SYNC + H_BACK;
   localparam int V_ACT_START = V_SYNC + V_BACK;

   if (((32'sd1 <<< X_WIDTH) - 32'sd1) < H_ACTIVE) begin : g_x_width_chk
      $error("vga_timing_gen: X_WIDTH too small for H_ACTIVE");
   end
   if (((32'sd1 <<< Y_WIDTH) - 32'sd1) < V_ACTIVE) begin : g_y_width_chk
      $error("vga_timing_gen: Y_WIDTH too small for V_ACTIVE");
   end

   // Reset values are the decode of position (0, 0). At that position x and y
   // are either both zero or the pixel is inactive, so the markers equal active.
   localparam logic HSYNC_RST = seg_in_sync(32'sd0, H_SYNC) ? HSYNC_POL : ~HSYNC_POL;
   localparam logic VSYNC_RST = seg_in_sync(32'sd0, V_SYNC) ? VSYNC_POL : ~VSYNC_POL;
   localparam logic H_ACT_RST = seg_in_active(32'sd0, H_ACT_START, H_ACTIVE);
   localparam logic V_ACT_RST = seg_in_active(32'sd0, V_ACT_START, V_ACTIVE);
   localparam logic ACT_RST   = H_ACT_RST & V_ACT_RST;
   localparam logic [X_WIDTH-1:0] X_RST = H_ACT_RST ? '0 : '1;
   localparam logic [Y_WIDTH-1:0] Y_RST = V_ACT_RST ? '0 : '1;

   logic               h_wrap_s;
   logic               h_in_sync_s;
   logic               h_in_active_s;
   logic [X_WIDTH-1:0] h_coord_s;
   logic               v_wrap_unused_s;
   logic               v_in_sync_s;
   logic               v_in_active_s;
   logic [Y_WIDTH-1:0] v_coord_s;
   logic               v_step_s;

   logic               hsync_q, hsync_d;
   logic               vsync_q, vsync_d;
   logic               active_q, active_d;
   logic [X_WIDTH-1:0] x_q, x_d;
   logic [Y_WIDTH-1:0] y_q, y_d;
   logic               line_start_q, line_start_d;
   logic               frame_start_q, frame_start_d;

   // The vertical axis advances only on the enabled edge that ends a line.
   assign v_step_s = ce & h_wrap_s;

`ifdef VGA_TIMING_PREFETCH_EN
   // Prefetch reset values are the decode of the position after (0, 0).
   localparam int FH_POS = (H_TOTAL > 32'sd1) ? 32'sd1 : 32'sd0;
   localparam int FV_POS = (H_TOTAL > 32'sd1) ? 32'sd0 : ((V_TOTAL > 32'sd1) ? 32'sd1 : 32'sd0);
   localparam logic FH_ACT_RST = seg_in_active(FH_POS, H_ACT_START, H_ACTIVE);
   localparam logic FV_ACT_RST = seg_in_active(FV_POS, V_ACT_START, V_ACTIVE);
   localparam logic [X_WIDTH-1:0] FX_RST = FH_ACT_RST ? X_WIDTH'(FH_POS - H_ACT_START) : '1;
   localparam logic [Y_WIDTH-1:0] FY_RST = FV_ACT_RST ? Y_WIDTH'(FV_POS - V_ACT_START) : '1;

   logic               h_next_wrap_s;
   logic               v_next_wrap_unused_s;
   logic               h_ahead_active_s;
   logic [X_WIDTH-1:0] h_ahead_coord_s;
   logic               v_ahead_active_s;
   logic [Y_WIDTH-1:0] v_ahead_coord_s;
   logic [X_WIDTH-1:0] fetch_x_q;
   logic [Y_WIDTH-1:0] fetch_y_q;
   logic               fetch_valid_q;
`endif

   vga_axis_counter #(
      .SYNC_LEN   (H_SYNC),
      .BACK_LEN   (H_BACK),
      .ACTIVE_LEN (H_ACTIVE),
      .FRONT_LEN  (H_FRONT),
      .COORD_W    (X_WIDTH)
   ) u_h_axis (
      .pixel_clock  (pixel_clock),
      .reset        (reset),
      .step         (ce),
`ifdef VGA_TIMING_PREFETCH_EN
      .ahead_step   (1'b1),
      .next_wrap    (h_next_wrap_s),
      .ahead_active (h_ahead_active_s),
      .ahead_coord  (h_ahead_coord_s),
`endif
      .wrap         (h_wrap_s),
      .in_sync      (h_in_sync_s),
      .in_active    (h_in_active_s),
      .coord        (h_coord_s)
   );

   vga_axis_counter #(
      .SYNC_LEN   (V_SYNC),
      .BACK_LEN   (V_BACK),
      .ACTIVE_LEN (V_ACTIVE),
      .FRONT_LEN  (V_FRONT),
      .COORD_W    (Y_WIDTH)
   ) u_v_axis (
      .pixel_clock  (pixel_clock),
      .reset        (reset),
      .step         (v_step_s),
`ifdef VGA_TIMING_PREFETCH_EN
      .ahead_step   (h_next_wrap_s),
      .next_wrap    (v_next_wrap_unused_s),
      .ahead_active (v_ahead_active_s),
      .ahead_coord  (v_ahead_coord_s),
`endif
      .wrap         (v_wrap_unused_s),
      .in_sync      (v_in_sync_s),
      .in_active    (v_in_active_s),
      .coord        (v_coord_s)
   );

   // Output decode of the next raster position.
   always_comb begin
      hsync_d       = h_in_sync_s ? HSYNC_POL : ~HSYNC_POL;
      vsync_d       = v_in_sync_s ? VSYNC_POL : ~VSYNC_POL;
      active_d      = h_in_active_s & v_in_active_s;
      x_d           = h_coord_s;
      y_d           = v_coord_s;
      line_start_d  = active_d & (h_coord_s == '0);
      frame_start_d = line_start_d & (v_coord_s == '0);
   end

   // Output registers.
   always_ff @(posedge pixel_clock or negedge reset) begin
      if (!reset) begin
         hsync_q       <= HSYNC_RST;
         vsync_q       <= VSYNC_RST;
         active_q      <= ACT_RST;
         x_q           <= X_RST;
         y_q           <= Y_RST;
         line_start_q  <= ACT_RST;
         frame_start_q <= ACT_RST;
      end else begin
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         active_q      <= active_d;
         x_q           <= x_d;
         y_q           <= y_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

`ifdef VGA_TIMING_PREFETCH_EN
   // Prefetch registers: decode of the position one enabled step ahead.
   always_ff @(posedge pixel_clock or negedge reset) begin
      if (!reset) begin
         fetch_x_q     <= FX_RST;
         fetch_y_q     <= FY_RST;
         fetch_valid_q <= FH_ACT_RST & FV_ACT_RST;
      end else begin
         fetch_x_q     <= h_ahead_coord_s;
         fetch_y_q     <= v_ahead_coord_s;
         fetch_valid_q <= h_ahead_active_s & v_ahead_active_s;
      end
   end

   assign fetch_x     = fetch_x_q;
   assign fetch_y     = fetch_y_q;
   assign fetch_valid = fetch_valid_q;
`endif

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign active      = active_q;
   assign x           = x_q;
   assign y           = y_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Two instances: a small raster (H 2/2/4/1, V 1/1/3/1, 4-bit coordinates)
// exercised with directed and random ce, and the default 640x480 raster with
// positive hsync. Expected outputs come from a reference model that maps the
// number of enabled edges since reset straight to a raster position.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

   localparam int SHS = 2, SHB = 2, SHA = 4, SHF = 1;
   localparam int SVS = 1, SVB = 1, SVA = 3, SVF = 1;

   logic pixel_clock = 1'b0;
   always #5 pixel_clock = ~pixel_clock;

   logic reset, ce, rst2;
   logic hsync, vsync, active, line_start, frame_start;
   logic [3:0] x, y;
   logic d_hsync, d_vsync, d_active, d_line_start, d_frame_start;
   logic [9:0] d_x, d_y;
`ifdef VGA_TIMING_PREFETCH_EN
   logic [3:0] fetch_x, fetch_y;
   logic       fetch_valid;
   logic [9:0] d_fetch_x, d_fetch_y;
   logic       d_fetch_valid;
`endif

   int     n_checks = 0;
   int     n_pass   = 0;
   longint n;
   bit     done2 = 1'b0;

   typedef struct {
      bit hs, vs, act, ls, fs;
      int x, y;
   } ref_t;

   vga_timing_gen #(
      .H_SYNC(SHS), .H_BACK(SHB), .H_ACTIVE(SHA), .H_FRONT(SHF),
      .V_SYNC(SVS), .V_BACK(SVB), .V_ACTIVE(SVA), .V_FRONT(SVF),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .X_WIDTH(4), .Y_WIDTH(4)
   ) dut (
      .pixel_clock(pixel_clock), .reset(reset), .ce(ce),
      .hsync(hsync), .vsync(vsync), .active(active), .x(x), .y(y),
`ifdef VGA_TIMING_PREFETCH_EN
      .fetch_x(fetch_x), .fetch_y(fetch_y), .fetch_valid(fetch_valid),
`endif
      .line_start(line_start), .frame_start(frame_start)
   );

   vga_timing_gen #(
      .HSYNC_POL(1'b1)
   ) dut_dflt (
      .pixel_clock(pixel_clock), .reset(rst2), .ce(1'b1),
      .hsync(d_hsync), .vsync(d_vsync), .active(d_active), .x(d_x), .y(d_y),
`ifdef VGA_TIMING_PREFETCH_EN
      .fetch_x(d_fetch_x), .fetch_y(d_fetch_y), .fetch_valid(d_fetch_valid),
`endif
      .line_start(d_line_start), .frame_start(d_frame_start)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Raster position after k enabled edges, decoded by the segment rules.
   function automatic ref_t ref_at(input longint k,
                                   input int hs_l, input int hb_l, input int ha_l, input int hf_l,
                                   input int vs_l, input int vb_l, input int va_l, input int vf_l,
                                   input bit hp, input bit vp, input int xw, input int yw);
      ref_t r;
      int ht, vt, h, v;
      bit hin, vin;
      ht  = hs_l + hb_l + ha_l + hf_l;
      vt  = vs_l + vb_l + va_l + vf_l;
      h   = int'(k % ht);
      v   = int'((k / ht) % vt);
      hin = (h >= hs_l + hb_l) && (h < hs_l + hb_l + ha_l);
      vin = (v >= vs_l + vb_l) && (v < vs_l + vb_l + va_l);
      r.hs  = (h < hs_l) ? hp : !hp;
      r.vs  = (v < vs_l) ? vp : !vp;
      r.act = hin && vin;
      r.x   = hin ? h - (hs_l + hb_l) : (1 << xw) - 1;
      r.y   = vin ? v - (vs_l + vb_l) : (1 << yw) - 1;
      r.ls  = r.act && (r.x == 0);
      r.fs  = r.ls && (r.y == 0);
      return r;
   endfunction

   function automatic ref_t small_ref(input longint k);
      return ref_at(k, SHS, SHB, SHA, SHF, SVS, SVB, SVA, SVF, 1'b0, 1'b0, 4, 4);
   endfunction

   function automatic ref_t dflt_ref(input longint k);
      return ref_at(k, 96, 48, 640, 16, 2, 33, 480, 10, 1'b1, 1'b0, 10, 10);
   endfunction

   task automatic compare_small();
      ref_t e;
      e = small_ref(n);
      check("ctrl", 32'({hsync, vsync, active, line_start, frame_start}),
            32'({e.hs, e.vs, e.act, e.ls, e.fs}));
      check("x", 32'(x), e.x);
      check("y", 32'(y), e.y);
      if (n == 0)  check("hsync_at_0", 32'(hsync), 32'd0);
      if (n == 2)  check("hsync_rise", 32'(hsync), 32'd1);
      if (n == 22) check("first_frame", 32'({frame_start, active, x, y}), 32'b1_1_0000_0000);
      if (n == 31) check("line_y1", 32'({line_start, y}), 32'b1_0001);
      if (n == 76) check("second_frame", 32'(frame_start), 32'd1);
`ifdef VGA_TIMING_PREFETCH_EN
      e = small_ref(n + 1);
      check("fetch_x", 32'(fetch_x), e.x);
      check("fetch_y", 32'(fetch_y), e.y);
      check("fetch_valid", 32'(fetch_valid), 32'(e.act));
      if (n == 21) check("fetch_first", 32'({fetch_valid, fetch_x}), 32'b1_0000);
      if ((n % 54) == 43) check("fetch_last_pix", 32'(fetch_valid), 32'd0);
`endif
   endtask

   task automatic check_reset_small();
      check("rst_ctrl", 32'({hsync, vsync, active, line_start, frame_start}), 32'b00000);
      check("rst_x", 32'(x), 32'd15);
      check("rst_y", 32'(y), 32'd15);
`ifdef VGA_TIMING_PREFETCH_EN
      check("rst_fetch", 32'({fetch_valid, fetch_x, fetch_y}), 32'b0_1111_1111);
`endif
   endtask

   task automatic step();
      @(posedge pixel_clock);
      if (ce) n++;
      #1;
      compare_small();
   endtask

   // Default-timing instance: model comparison plus sync pulse lengths.
   initial begin
      int hs_hi, vs_lo;
      ref_t e;
      hs_hi = 0;
      vs_lo = 0;
      @(posedge rst2);
      #1;
      for (longint m = 0; m < 1700; m++) begin
         if (m > 0) begin
            @(posedge pixel_clock);
            #1;
         end
         e = dflt_ref(m);
         check("d_ctrl", 32'({d_hsync, d_vsync, d_active, d_line_start, d_frame_start}),
               32'({e.hs, e.vs, e.act, e.ls, e.fs}));
         check("d_x", 32'(d_x), e.x);
         check("d_y", 32'(d_y), e.y);
         if (m < 800 && d_hsync) hs_hi++;
         if (!d_vsync) vs_lo++;
      end
      check("d_hsync_high_per_line", 32'(hs_hi), 32'd96);
      check("d_vsync_low_2_lines", 32'(vs_lo), 32'd1600);
      done2 = 1'b1;
   end

   initial begin
      reset = 1'b0;
      rst2  = 1'b0;
      ce    = 1'b1;
      n     = 0;
      repeat (3) @(posedge pixel_clock);
      #1;
      check_reset_small();
      check("d_rst_ctrl", 32'({d_hsync, d_vsync, d_active, d_line_start, d_frame_start}), 32'b10000);
      check("d_rst_xy", 32'({d_x, d_y}), 32'hFFFFF);

      @(negedge pixel_clock);
      reset = 1'b1;
      rst2  = 1'b1;
      #1;
      compare_small();

      // First frame and the start of the second with ce held high.
      repeat (80) step();

      // Stall on x = 2.
      for (int i = 0; i < 40 && (n % 9) != 6; i++) step();
      check("reach_x2", 32'(x), 32'd2);
      ce = 1'b0;
      repeat (5) step();
      check("stall_x", 32'(x), 32'd2);
      ce = 1'b1;
      step();
      check("resume_x", 32'(x), 32'd3);

      // Random enable pattern.
      repeat (400) begin
         ce = ($urandom_range(0, 3) != 0);
         step();
      end

      // Reset in the middle of the frame at y = 1, x = 3.
      ce = 1'b1;
      for (int i = 0; i < 120 && (n % 54) != 34; i++) step();
      check("reach_mid", 32'({y, x}), 32'b0001_0011);
      #1 reset = 1'b0;
      #1;
      check_reset_small();
      n = 0;
      @(negedge pixel_clock);
      reset = 1'b1;
      #1;
      compare_small();
      repeat (80) step();

      for (int i = 0; i < 3000 && !done2; i++) @(posedge pixel_clock);
      check("dflt_done", 32'(done2), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator producing horizontal and vertical sync, the active-video flag, pixel coordinates and frame/line markers from a single pixel clock. It generalises the single-axis sync generator: both axes run in one block, sync polarity is configurable, and the pixel clock can be stalled with a clock enable. It sits between the pixel clock source and the frame-buffer reader and colour output stage.

## Interface
- H_SYNC, 96, horizontal sync pulse length in pixels
- H_BACK, 48, horizontal back porch length
- H_ACTIVE, 640, horizontal active pixels
- H_FRONT, 16, horizontal front porch length
- V_SYNC, 2, vertical sync length in lines
- V_BACK, 33, vertical back porch length
- V_ACTIVE, 480, vertical active lines
- V_FRONT, 10, vertical front porch length
- HSYNC_POL, 0, asserted level of hsync (0 = active-low)
- VSYNC_POL, 0, asserted level of vsync
- X_WIDTH, 10, width of x; elaboration error if 2^X_WIDTH − 1 < H_ACTIVE
- Y_WIDTH, 10, width of y; elaboration error if 2^Y_WIDTH − 1 < V_ACTIVE

Ports:
- pixel_clock  in  1  pixel clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- ce  in  1  pixel-step enable; state holds while low
- hsync  out  1  horizontal sync, level per HSYNC_POL
- vsync  out  1  vertical sync, level per VSYNC_POL
- active  out  1  high when both axes are in their active region
- x  out  X_WIDTH  active column, all-ones outside horizontal active
- y  out  Y_WIDTH  active row, all-ones outside vertical active
- line_start  out  1  high at x = 0 of every active line
- frame_start  out  1  high at x = 0, y = 0

## Operation
- Segment order on each axis: sync, back porch, active, front porch.
- H_TOTAL = sum of the four H parameters. V_TOTAL = sum of the four V parameters.
- h_cnt runs 0..H_TOTAL−1. It increments when ce = 1 and wraps to 0.
- v_cnt increments only on the ce cycle where h_cnt wraps. It runs 0..V_TOTAL−1 and wraps to 0.
- Counter widths are $clog2 of the respective total. Coordinates are computed with no truncation.
- Horizontal decode:
  - sync: h_cnt < H_SYNC
  - active: H_SYNC+H_BACK ≤ h_cnt < H_SYNC+H_BACK+H_ACTIVE
  - x = h_cnt − (H_SYNC+H_BACK) when active, else all-ones
- Vertical decode is identical, using v_cnt and y.
- hsync = HSYNC_POL while in horizontal sync, else ~HSYNC_POL. vsync follows the same rule with VSYNC_POL.
- active = h_active & v_active.
- line_start = active & (x == 0). frame_start = line_start & (y == 0).
- All outputs are registered from the next-state decode, so they always match the current (h_cnt, v_cnt) and are glitch-free.
- ce low: counters and all outputs hold. Pulses stay high for as long as the stall lasts on their position.

## Timing
- Reset values (counters 0,0):
  - hsync = HSYNC_POL, vsync = VSYNC_POL
  - active = 0, line_start = 0, frame_start = 0
  - x = all-ones, y = all-ones
- Reset asserted mid-frame clears everything immediately (asynchronous).
- After reset release, the first enabled edge moves to h_cnt = 1.
- Latency from counter state to outputs: 0 cycles (outputs are aligned with the counters).
- Frame period: H_TOTAL × V_TOTAL enabled cycles.
- The first active pixel occurs (H_SYNC+H_BACK) + (V_SYNC+V_BACK)×H_TOTAL enabled cycles after release.
- Wrap case (h_cnt = H_TOTAL−1 and v_cnt = V_TOTAL−1): both axes return to 0 on the same edge, and sync levels update together.

## Configuration
- VGA_TIMING_PREFETCH_EN defined: adds three extra outputs.
  - fetch_x (X_WIDTH), fetch_y (Y_WIDTH), fetch_valid (1).
  - They equal the x / y / active values for the position one enabled step ahead, wrap included.
  - Purpose: a frame buffer with one-cycle read latency can present pixel data aligned with active.
  - Reset values reflect position (1, 0).
- Undefined: these ports and their logic are absent. The rest of the behaviour is unchanged.

## Structure
- Package vga_timing_pkg holds:
  - default timing constants for 640×480@60
  - a polarity enum (SYNC_NEG = 0, SYNC_POS = 1)
  - a function returning the total length of an axis from its four segment lengths
- Sub-module vga_axis_counter, instantiated once per axis. It is parametrised by the four segment lengths and the coordinate width, and has:
  - inputs: step (advance enable)
  - outputs: wrap, in_sync, in_active, coord

## Test plan
Small-parameter runs use H = 2/2/4/1 (H_TOTAL 9) and V = 1/1/3/1 (V_TOTAL 6), with ce = 1 unless stated.

- Reset check: release reset with the small parameters → cycle 0 shows hsync = 0, vsync = 0, x = 15, y = 15, active = 0. hsync rises at h_cnt = 2.
- First frame: at enabled cycle 22, frame_start = 1, x = 0, y = 0, active = 1. At cycle 31, line_start = 1, y = 1. At cycle 76, the next frame_start occurs (period 54).
- ce stall: hold ce = 0 for 5 cycles at x = 2 → all outputs frozen. With ce restored, x = 3 on the next edge.
- Mid-frame reset: assert reset at y = 1, x = 3 → outputs take their reset values with no clock edge. The sequence restarts from cycle 0.
- Polarity and defaults: HSYNC_POL = 1 with default 640×480 timing → hsync is high for exactly 96 cycles per 800-cycle line. vsync is low for 2 lines of every 525.
- Prefetch (macro defined): fetch_x = 0 and fetch_valid = 1 at cycle 21. At the last active pixel of the frame, fetch_valid = 0.
